// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Build option: define UART_TX_PARITY_EN to add the even parity bit and its state.
package uart_pkg;

    localparam logic START_BIT_VAL = 1'b0;
    localparam logic STOP_BIT_VAL  = 1'b1;
    localparam logic IDLE_LINE_VAL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-source side handshake plus serial line of the UART transmitter.
// The master modport is the word source; the slave modport is uart_tx.
interface uart_tx_if #(
    parameter int NUM_DATA_BITS = 8
);
    logic                     tx_start;
    logic [NUM_DATA_BITS-1:0] tx_data;
    logic                     serial_out;
    logic                     tx_busy;
    logic                     tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  serial_out,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output serial_out,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/flex_pts_sr.sv
// Parameterized parallel-to-serial shift register, LSB shifted out first.
// Parallel load has priority over shift; zeros enter at the MSB.
// next_out exposes the bit that becomes the LSB after the next shift.
module flex_pts_sr #(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                load_en,
    input  logic                shift_en,
    input  logic [NUM_BITS-1:0] par_in,
    output logic                serial_out,
    output logic                next_out
);

    logic [NUM_BITS-1:0] sr_reg;
    logic [NUM_BITS-1:0] sr_next;

    generate
        for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_bit
            if (gi == NUM_BITS - 1) begin : g_msb
                assign sr_next[gi] = load_en  ? par_in[gi] :
                                     shift_en ? 1'b0       : sr_reg[gi];
            end else begin : g_lower
                assign sr_next[gi] = load_en  ? par_in[gi]     :
                                     shift_en ? sr_reg[gi + 1] : sr_reg[gi];
            end
        end
    endgenerate

    // Register the shift contents; reset clears the word.
    always_ff @(posedge clk) begin
        if (srst) begin
            sr_reg <= '0;
        end else begin
            sr_reg <= sr_next;
        end
    end

    assign serial_out = sr_reg[0];
    assign next_out   = sr_reg[1];

endmodule

// File: rtl/uart_tx.sv
// UART frame transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Build option: define UART_TX_PARITY_EN to insert the even parity bit after the data.
// serial_out is registered, so the line value is computed from the next state.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 10,
    parameter int NUM_DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(NUM_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DATA_BITS - 1);

    tx_state_e         state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg,   cnt_next;
    logic [IDX_W-1:0]  idx_reg,   idx_next;
    logic              serial_reg, serial_next;
    logic              done_reg,   done_next;
    logic              load_en;
    logic              shift_en;
    logic              bit_end;
    logic              sr_lsb;
    logic              sr_lookahead;
`ifdef UART_TX_PARITY_EN
    logic              parity_reg, parity_next;
`endif

    flex_pts_sr #(
        .NUM_BITS (NUM_DATA_BITS)
    ) u_sr (
        .clk        (clk),
        .srst       (rst),
        .load_en    (load_en),
        .shift_en   (shift_en),
        .par_in     (bus.tx_data),
        .serial_out (sr_lsb),
        .next_out   (sr_lookahead)
    );

    assign bit_end = (cnt_reg == CNT_LAST);

    // Next-state, bit-time counter, bit index and registered line value.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        idx_next    = idx_reg;
        done_next   = 1'b0;
        load_en     = 1'b0;
        shift_en    = 1'b0;
        serial_next = IDLE_LINE_VAL;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif

        // Every non-idle state times one bit; wrapping to zero also clears
        // the counter for whichever state comes next.
        if (state_reg != ST_IDLE) begin
            cnt_next = bit_end ? '0 : cnt_reg + CNT_W'(1);
        end

        case (state_reg)
            ST_IDLE: begin
                if (bus.tx_start) begin
                    load_en    = 1'b1;
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = ST_START;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^bus.tx_data;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (idx_reg == IDX_LAST) begin
                        idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Line value for the cycle after this edge. In DATA the shift
        // register moves on the same edge, so look one bit ahead then.
        case (state_next)
            ST_IDLE:   serial_next = IDLE_LINE_VAL;
            ST_START:  serial_next = START_BIT_VAL;
            ST_DATA:   serial_next = shift_en ? sr_lookahead : sr_lsb;
`ifdef UART_TX_PARITY_EN
            ST_PARITY: serial_next = parity_reg;
`endif
            ST_STOP:   serial_next = STOP_BIT_VAL;
            default:   serial_next = IDLE_LINE_VAL;
        endcase
    end

    // State register; reset aborts any frame without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            serial_reg <= IDLE_LINE_VAL;
            done_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            serial_reg <= serial_next;
            done_reg   <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    assign bus.serial_out = serial_reg;
    assign bus.tx_busy    = (state_reg != ST_IDLE);
    assign bus.tx_done    = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: vector table, random frames against a
// frame-level line model, and hand sequences for back-to-back, ignored
// request and mid-frame reset. Honours UART_TX_PARITY_EN like the RTL.
module tb_uart_tx;

    localparam int C = 10;
    localparam int N = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = N + 3;
`else
    localparam int FRAME_BITS = N + 2;
`endif
    localparam int L = FRAME_BITS * C;

    typedef struct {
        logic [N-1:0] data;
        logic         exp_b0;
        logic         exp_par;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic cap_bits [0:FRAME_BITS-1];
    vec_t vecs [0:4];

    uart_tx_if #(.NUM_DATA_BITS(N)) bus ();

    uart_tx #(
        .CLKS_PER_BIT  (C),
        .NUM_DATA_BITS (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Line value j cycles after acceptance, from the frame layout alone.
    function automatic logic model_line(input logic [N-1:0] d, input int j);
        int bt;
        bt = j / C;
        if (bt == 0) return 1'b0;
        if (bt <= N) return d[bt-1];
`ifdef UART_TX_PARITY_EN
        if (bt == N + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    // Requires the DUT idle; returns #1 after the accepting edge.
    task automatic start_frame(input logic [N-1:0] d);
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        tick();
        bus.tx_start = 1'b0;
    endtask

    // Called #1 after the accepting edge; checks every cycle of the frame
    // and the done cycle. poke_at >= 0 raises a stray request mid-frame.
    task automatic check_frame(input logic [N-1:0] d, input int poke_at, input bit tail_check);
        for (int j = 0; j < L; j++) begin
            if (j > 0) tick();
            if (poke_at >= 0 && j == poke_at) begin
                bus.tx_start = 1'b1;
                bus.tx_data  = ~d;
            end
            if (poke_at >= 0 && j == poke_at + 1) bus.tx_start = 1'b0;
            chk($sformatf("line d=%h cyc=%0d", d, j), bus.serial_out, model_line(d, j));
            chk($sformatf("busy d=%h cyc=%0d", d, j), bus.tx_busy, 1'b1);
            chk($sformatf("done_early d=%h cyc=%0d", d, j), bus.tx_done, 1'b0);
            if (j % C == C / 2) cap_bits[j / C] = bus.serial_out;
        end
        tick();
        chk($sformatf("done_pulse d=%h", d), bus.tx_done, 1'b1);
        chk($sformatf("busy_at_done d=%h", d), bus.tx_busy, 1'b0);
        chk($sformatf("line_at_done d=%h", d), bus.serial_out, 1'b1);
        if (tail_check) begin
            tick();
            chk($sformatf("done_single d=%h", d), bus.tx_done, 1'b0);
            chk($sformatf("idle_after d=%h", d), bus.tx_busy, 1'b0);
        end
        $display("frame data=%h cycles=%0d errors_so_far=%0d", d, L, n_err);
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, exp_b0: 1'b1, exp_par: 1'b0};
        vecs[1] = '{data: 8'h07, exp_b0: 1'b1, exp_par: 1'b1};
        vecs[2] = '{data: 8'h3C, exp_b0: 1'b0, exp_par: 1'b0};
        vecs[3] = '{data: 8'h80, exp_b0: 1'b0, exp_par: 1'b1};
        vecs[4] = '{data: 8'h00, exp_b0: 1'b0, exp_par: 1'b0};

        // Reset, including a request presented during reset.
        rst          = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_data  = '0;
        tick();
        tick();
        chk("reset_line", bus.serial_out, 1'b1);
        chk("reset_busy", bus.tx_busy, 1'b0);
        chk("reset_done", bus.tx_done, 1'b0);
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'h55;
        tick();
        chk("rst_wins_busy", bus.tx_busy, 1'b0);
        chk("rst_wins_line", bus.serial_out, 1'b1);
        bus.tx_start = 1'b0;
        rst          = 1'b0;
        $display("reset sequence errors_so_far=%0d", n_err);

        // Idle line for 50 cycles.
        for (int i = 0; i < 50; i++) begin
            tick();
            chk($sformatf("idle_line %0d", i), bus.serial_out, 1'b1);
            chk($sformatf("idle_busy %0d", i), bus.tx_busy, 1'b0);
            chk($sformatf("idle_done %0d", i), bus.tx_done, 1'b0);
        end

        // Vector table.
        for (int v = 0; v < 5; v++) begin
            start_frame(vecs[v].data);
            check_frame(vecs[v].data, -1, 1'b1);
            chk($sformatf("vec%0d_bit0", v), cap_bits[1], vecs[v].exp_b0);
`ifdef UART_TX_PARITY_EN
            chk($sformatf("vec%0d_parity", v), cap_bits[N+1], vecs[v].exp_par);
`endif
        end

        // Random frames with random idle gaps.
        for (int r = 0; r < 20; r++) begin
            logic [N-1:0] d;
            int gap;
            d   = N'($urandom());
            gap = int'($urandom_range(0, 5));
            for (int g = 0; g < gap; g++) tick();
            start_frame(d);
            check_frame(d, -1, 1'b1);
        end

        // Back-to-back with tx_start held; data changes during frame 1.
        bus.tx_data  = 8'h3C;
        bus.tx_start = 1'b1;
        tick();
        bus.tx_data = 8'hC3;
        check_frame(8'h3C, -1, 1'b0);
        tick();
        bus.tx_start = 1'b0;
        check_frame(8'hC3, -1, 1'b1);

        // Stray request at cycle 30 of an active frame.
        start_frame(8'h5A);
        check_frame(8'h5A, 30, 1'b1);

        // Reset at cycle 45 of a frame, then a clean 0xFF frame.
        start_frame(8'h96);
        for (int j = 1; j <= 45; j++) tick();
        rst = 1'b1;
        tick();
        chk("abort_line", bus.serial_out, 1'b1);
        chk("abort_busy", bus.tx_busy, 1'b0);
        chk("abort_done", bus.tx_done, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 120; i++) begin
            tick();
            chk($sformatf("post_abort_done %0d", i), bus.tx_done, 1'b0);
            chk($sformatf("post_abort_line %0d", i), bus.serial_out, 1'b1);
        end
        $display("abort sequence errors_so_far=%0d", n_err);
        start_frame(8'hFF);
        check_frame(8'hFF, -1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
